// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch front end: owns the PC, keeps one request in flight and hands words to decode.
// Build option: define ILLEGAL_OPCODE_CHECK_EN to flag opcodes outside the supported R/load/store/branch set.
module instr_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      opcode,
   output logic            instr_illegal,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            misalign_err
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              drop_q, drop_d;
   logic [31:0]       instr_q, instr_d;
   logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
   logic              valid_q, valid_d;
   logic              misalign_q, misalign_d;
   // Keeps imem_req low during reset and the first cycle after release.
   logic              started_q;
   logic              grant_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
         started_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
         started_q  <= 1'b1;
      end
   end

   assign grant_ok = started_q && imem_gnt;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      misalign_d = 1'b0;

      unique case (state_q)
         ST_REQ: begin
            if (grant_ok) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  instr_d    = imem_rdata;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
                  pc_d       = pc_q + XLEN'(4);
                  state_d    = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            // Clearing the word keeps opcode at zero whenever instr_valid is low.
            if (instr_ready) begin
               valid_d    = 1'b0;
               instr_d    = '0;
               instr_pc_d = '0;
               state_d    = ST_REQ;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase

      // A redirect overrides whatever the state machine decided above.
      if (redirect) begin
         pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
         misalign_d = |redirect_pc[1:0];
         valid_d    = 1'b0;
         instr_d    = '0;
         instr_pc_d = '0;
         unique case (state_q)
            ST_REQ: begin
               if (grant_ok) begin
                  state_d = ST_WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  state_d = ST_REQ;
                  drop_d  = 1'b0;
               end else begin
                  state_d = ST_WAIT;
                  drop_d  = 1'b1;
               end
            end
            default: begin
               state_d = ST_REQ;
            end
         endcase
      end
   end

   assign imem_req     = started_q && (state_q == ST_REQ);
   assign imem_addr    = pc_q;
   assign instr_valid  = valid_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign opcode       = instr_q[6:0];
   assign misalign_err = misalign_q;

`ifdef ILLEGAL_OPCODE_CHECK_EN
   logic opcode_supported;
   always_comb begin
      unique case (instr_q[6:0])
         7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011: opcode_supported = 1'b1;
         default:                                        opcode_supported = 1'b0;
      endcase
   end
   assign instr_illegal = valid_q && !opcode_supported;
`else
   assign instr_illegal = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential instruction-fetch front end producing the 32-bit instruction word whose opcode field drives the main controller decoder.
- Owns the PC and issues one request at a time to instruction memory over a req/gnt/rvalid interface.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Accepts taken-branch redirects and discards any stale in-flight response.

Parameters:
XLEN, 32, PC and address width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  fetch request valid.
imem_addr  output  XLEN  fetch address (word aligned).
imem_gnt  input  1  memory accepted the request this cycle.
imem_rvalid  input  1  response data valid; at least 1 cycle after gnt.
imem_rdata  input  32  instruction word.
instr_valid  output  1  instr/instr_pc/opcode are valid.
instr_ready  input  1  decode consumes the instruction.
instr  output  32  fetched instruction.
instr_pc  output  XLEN  address of instr.
opcode  output  7  instr[6:0], feeds the controller.
instr_illegal  output  1  opcode not supported (see Optional Feature).
redirect  input  1  taken branch, one-cycle pulse.
redirect_pc  input  XLEN  branch target.
misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=REQ, drop=0.
  - instr_valid=0, instr=0, instr_pc=0, imem_req=0, misalign_err=0.
  - imem_req rises in the first clk after release.
- State machine has three states: REQ, WAIT, HOLD.
  - REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> WAIT; otherwise stay, holding the address stable.
  - WAIT: imem_req=0. On imem_rvalid:
    - drop=1 -> clear drop, go to REQ (pc already holds the new target).
    - drop=0 -> instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to HOLD.
  - HOLD: outputs held stable while instr_valid && !instr_ready. On instr_ready=1 -> instr_valid<=0, go to REQ.
- Only one outstanding request at a time; a new imem_req is never issued before the previous response.
- Throughput is at most one instruction per 3 cycles (gnt, rvalid, ready).
- PC arithmetic: pc+4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Redirect (redirect=1) has highest priority in every state:
  - pc<=redirect_pc with bits[1:0] forced to 0.
  - misalign_err pulses if redirect_pc[1:0] != 0.
  - instr_valid<=0.
  - REQ with gnt in the same cycle -> WAIT with drop=1.
  - REQ without gnt -> stay REQ; the address changes next cycle.
  - WAIT without rvalid -> drop<=1, stay WAIT.
  - WAIT with rvalid in the same cycle -> response discarded, go to REQ.
  - HOLD -> REQ. A same-cycle instr_ready is ignored; the instruction counts as flushed, not consumed.
- Redirects in consecutive cycles: the last one wins; drop stays set until the single in-flight response returns.
- opcode is always instr[6:0]; it is 0 while instr_valid=0, because instr is cleared on redirect and reset.
- imem_rvalid while in REQ or HOLD is ignored (protocol violation, no state change).

Optional Feature:
Macro ILLEGAL_OPCODE_CHECK_EN.
- Defined: instr_illegal = instr_valid && opcode not in {0110011, 0000011, 0100011, 1100011}. The instruction is still delivered normally.
- Undefined: instr_illegal is tied to 0 and no compare logic is built.

Test Plan:
- Reset release, gnt immediate, rvalid 2 cycles later with rdata=32'h00A00533 -> imem_addr=0, then instr_valid=1, instr_pc=0, opcode=0110011. Next request is at address 4.
- instr_ready held low 5 cycles -> instr/instr_pc/opcode stable, no imem_req. Ready pulse -> instr_valid=0 the next cycle and imem_req=1 at the next PC.
- redirect to 32'h100 while in WAIT, then rvalid with 32'h00002083 -> response dropped (instr_valid stays 0). Next imem_addr=32'h100.
- redirect and rvalid in the same cycle, redirect_pc=32'h202 -> misalign_err pulses, response dropped, imem_addr=32'h200.
- With ILLEGAL_OPCODE_CHECK_EN, rdata=32'h00000013 -> instr_illegal=1. With 32'h00C12223 (S-type) -> instr_illegal=0. Macro undefined -> always 0.
- rst_n asserted mid-WAIT -> all outputs 0 immediately. After release, fetch restarts at RESET_PC and the late rvalid from the old request is ignored.
